// File: rtl/ccr_unit_pkg.sv
// Condition-code register shared definitions: branch encodings,
// flag bit positions and shadow-stack depth, also used by the branch unit.
package ccr_unit_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JZ   = 3'd1,
        BR_JN   = 3'd2,
        BR_JC   = 3'd3,
        BR_JV   = 3'd4,
        BR_LOOP = 3'd5,
        BR_JMP  = 3'd6,
        BR_RET  = 3'd7
    } br_type_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [1:0] STACK_DEPTH = 2'd2;

endpackage

// File: rtl/ccr_unit_if.sv
// Control and status bundle between the pipeline and the condition-code unit.
interface ccr_unit_if
    import ccr_unit_pkg::*;
();

    logic [3:0] alu_flags;
    logic [3:0] flag_we;
    logic       setc;
    logic       clrc;
    br_type_e   br_type;
    logic       br_taken;
    logic       int_save;
    logic       rti_restore;
    logic       stall;
    logic [3:0] flag_mask;
    logic [3:0] flag_fwd;
    logic [1:0] save_depth;
    logic       stack_err;

    modport master (
        output alu_flags, flag_we, setc, clrc,
        output br_type, br_taken, int_save, rti_restore, stall,
        input  flag_mask, flag_fwd, save_depth, stack_err
    );

    modport slave (
        input  alu_flags, flag_we, setc, clrc,
        input  br_type, br_taken, int_save, rti_restore, stall,
        output flag_mask, flag_fwd, save_depth, stack_err
    );

endinterface

// File: rtl/ccr_shadow_stack.sv
// Two-entry LIFO holding flags across interrupt entry/RTI,
// with sticky overflow/underflow/conflict detection.
module ccr_shadow_stack
    import ccr_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       save,
    input  logic       restore,
    input  logic       stall,
    input  logic [3:0] push_data,
    output logic [3:0] top,
    output logic       pop_ok,
    output logic [1:0] depth,
    output logic       err
);

    logic [3:0] entry [2];
    logic       push_ok;
    logic       conflict;
    logic       overflow;
    logic       underflow;

    always_comb begin
        conflict  = save & restore;
        overflow  = save & ~restore & (depth == STACK_DEPTH);
        underflow = restore & ~save & (depth == 2'd0);
        push_ok   = save & ~restore & ~overflow & ~stall;
        pop_ok    = restore & ~save & ~underflow & ~stall;
        // depth 1 -> slot 0, depth 2 -> slot 1
        top       = entry[depth[1]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry[0] <= '0;
            entry[1] <= '0;
            depth    <= '0;
            err      <= 1'b0;
        end else if (!stall) begin
            if (push_ok) begin
                entry[depth[0]] <= push_data;
                depth           <= depth + 2'd1;
            end else if (pop_ok) begin
                depth <= depth - 2'd1;
            end
            if (overflow | underflow | conflict)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register: per-flag update with branch clear, ALU write,
// SETC/CLRC and RTI restore, plus a combinational bypass of the next value.
module ccr_unit
    import ccr_unit_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    ccr_unit_if.slave bus
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] stack_top;
    logic       pop_ok;

    ccr_shadow_stack u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .save      (bus.int_save),
        .restore   (bus.rti_restore),
        .stall     (bus.stall),
        .push_data (flags_q),
        .top       (stack_top),
        .pop_ok    (pop_ok),
        .depth     (bus.save_depth),
        .err       (bus.stack_err)
    );

    // Later assignments win: branch-clear < ALU < SETC/CLRC < restore.
    always_comb begin
        flags_d = flags_q;
        if (bus.br_taken) begin
            case (bus.br_type)
                BR_JZ:   flags_d[FLAG_Z] = 1'b0;
                BR_JN:   flags_d[FLAG_N] = 1'b0;
                BR_JC:   flags_d[FLAG_C] = 1'b0;
                BR_JV:   flags_d[FLAG_V] = 1'b0;
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++)
            if (bus.flag_we[i])
                flags_d[i] = bus.alu_flags[i];
        if (bus.clrc)
            flags_d[FLAG_C] = 1'b0;
        else if (bus.setc)
            flags_d[FLAG_C] = 1'b1;
        if (pop_ok)
            flags_d = stack_top;
        if (bus.stall)
            flags_d = flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_q <= '0;
        else
            flags_q <= flags_d;
    end

    assign bus.flag_mask = flags_q;
    assign bus.flag_fwd  = flags_d;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed bench for ccr_unit: reset, branch clear, precedence,
// shadow-stack nesting, error cases and stall.
module tb_ccr_unit;
    import ccr_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    ccr_unit_if bus ();

    ccr_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.alu_flags   = 4'b0000;
        bus.flag_we     = 4'b0000;
        bus.setc        = 1'b0;
        bus.clrc        = 1'b0;
        bus.br_type     = BR_NONE;
        bus.br_taken    = 1'b0;
        bus.int_save    = 1'b0;
        bus.rti_restore = 1'b0;
        bus.stall       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic load(input logic [3:0] v);
        idle();
        bus.flag_we   = 4'b1111;
        bus.alu_flags = v;
        step();
        idle();
    endtask

    task automatic test_reset();
        load(4'b1111);
        tests++;
        if (bus.flag_mask !== 4'b1111) begin
            fails++;
            $display("FAIL load_ones: got %b want 1111", bus.flag_mask);
        end
        bus.int_save = 1'b1;
        step();
        idle();
        rst_n = 1'b0;
        #2;
        tests++;
        if (bus.flag_mask !== 4'b0000 || bus.save_depth !== 2'd0
            || bus.stack_err !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got %b/%0d/%b want 0000/0/0",
                     bus.flag_mask, bus.save_depth, bus.stack_err);
        end
        rst_n = 1'b1;
        step();
        // stack contents were discarded: restore now underflows
        bus.rti_restore = 1'b1;
        step();
        idle();
        tests++;
        if (bus.flag_mask !== 4'b0000 || bus.save_depth !== 2'd0
            || bus.stack_err !== 1'b1) begin
            fails++;
            $display("FAIL reset_discard: got %b/%0d/%b want 0000/0/1",
                     bus.flag_mask, bus.save_depth, bus.stack_err);
        end
        do_reset();
    endtask

    task automatic test_branch_clear();
        load(4'b0101);
        bus.br_type  = BR_JZ;
        bus.br_taken = 1'b1;
        #1;
        tests++;
        if (bus.flag_fwd !== 4'b0100) begin
            fails++;
            $display("FAIL jz_fwd: got %b want 0100", bus.flag_fwd);
        end
        step();
        tests++;
        if (bus.flag_mask !== 4'b0100) begin
            fails++;
            $display("FAIL jz_clear: got %b want 0100", bus.flag_mask);
        end
        load(4'b0101);
        bus.br_type  = BR_LOOP;
        bus.br_taken = 1'b1;
        step();
        tests++;
        if (bus.flag_mask !== 4'b0101) begin
            fails++;
            $display("FAIL loop_noclear: got %b want 0101", bus.flag_mask);
        end
        load(4'b1111);
        bus.br_type  = BR_JN;
        bus.br_taken = 1'b0;
        step();
        tests++;
        if (bus.flag_mask !== 4'b1111) begin
            fails++;
            $display("FAIL jn_nottaken: got %b want 1111", bus.flag_mask);
        end
        bus.br_taken = 1'b1;
        step();
        bus.br_type = BR_JC;
        step();
        bus.br_type = BR_JV;
        step();
        tests++;
        if (bus.flag_mask !== 4'b0001) begin
            fails++;
            $display("FAIL jn_jc_jv: got %b want 0001", bus.flag_mask);
        end
        idle();
    endtask

    task automatic test_precedence();
        load(4'b0000);
        bus.alu_flags = 4'b1111;
        bus.flag_we   = 4'b0100;
        bus.clrc      = 1'b1;
        #1;
        tests++;
        if (bus.flag_fwd !== 4'b0000) begin
            fails++;
            $display("FAIL clrc_fwd: got %b want 0000", bus.flag_fwd);
        end
        step();
        tests++;
        if (bus.flag_mask !== 4'b0000) begin
            fails++;
            $display("FAIL clrc_over_alu: got %b want 0000", bus.flag_mask);
        end
        bus.clrc = 1'b0;
        bus.setc = 1'b1;
        bus.alu_flags = 4'b0000;
        step();
        tests++;
        if (bus.flag_mask !== 4'b0100) begin
            fails++;
            $display("FAIL setc_over_alu: got %b want 0100", bus.flag_mask);
        end
        idle();
        bus.setc = 1'b1;
        bus.clrc = 1'b1;
        step();
        tests++;
        if (bus.flag_mask !== 4'b0000) begin
            fails++;
            $display("FAIL setc_clrc: got %b want 0000", bus.flag_mask);
        end
        load(4'b0011);
        bus.br_type   = BR_JZ;
        bus.br_taken  = 1'b1;
        bus.flag_we   = 4'b0001;
        bus.alu_flags = 4'b0001;
        step();
        tests++;
        if (bus.flag_mask !== 4'b0011) begin
            fails++;
            $display("FAIL alu_over_br: got %b want 0011", bus.flag_mask);
        end
        idle();
    endtask

    task automatic test_nesting();
        do_reset();
        load(4'b0011);
        bus.int_save = 1'b1;
        step();
        idle();
        tests++;
        if (bus.save_depth !== 2'd1) begin
            fails++;
            $display("FAIL nest_d1: got %0d want 1", bus.save_depth);
        end
        load(4'b1000);
        bus.int_save = 1'b1;
        step();
        tests++;
        if (bus.save_depth !== 2'd2) begin
            fails++;
            $display("FAIL nest_d2: got %0d want 2", bus.save_depth);
        end
        load(4'b0000);
        tests++;
        if (bus.save_depth !== 2'd2 || bus.flag_mask !== 4'b0000) begin
            fails++;
            $display("FAIL nest_write: got %0d/%b want 2/0000",
                     bus.save_depth, bus.flag_mask);
        end
        bus.rti_restore = 1'b1;
        step();
        tests++;
        if (bus.flag_mask !== 4'b1000 || bus.save_depth !== 2'd1) begin
            fails++;
            $display("FAIL pop1: got %b/%0d want 1000/1",
                     bus.flag_mask, bus.save_depth);
        end
        bus.flag_we   = 4'b1111;
        bus.alu_flags = 4'b1111;
        bus.setc      = 1'b1;
        step();
        idle();
        tests++;
        if (bus.flag_mask !== 4'b0011 || bus.save_depth !== 2'd0
            || bus.stack_err !== 1'b0) begin
            fails++;
            $display("FAIL pop2: got %b/%0d/%b want 0011/0/0",
                     bus.flag_mask, bus.save_depth, bus.stack_err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        load(4'b0001);
        bus.int_save = 1'b1;
        step();
        step();
        bus.flag_we   = 4'b1111;
        bus.alu_flags = 4'b0110;
        step();
        idle();
        tests++;
        if (bus.save_depth !== 2'd2 || bus.stack_err !== 1'b1
            || bus.flag_mask !== 4'b0110) begin
            fails++;
            $display("FAIL overflow: got %0d/%b/%b want 2/1/0110",
                     bus.save_depth, bus.stack_err, bus.flag_mask);
        end
        do_reset();
        load(4'b0101);
        bus.rti_restore = 1'b1;
        step();
        idle();
        step();
        tests++;
        if (bus.flag_mask !== 4'b0101 || bus.stack_err !== 1'b1
            || bus.save_depth !== 2'd0) begin
            fails++;
            $display("FAIL underflow: got %b/%b/%0d want 0101/1/0",
                     bus.flag_mask, bus.stack_err, bus.save_depth);
        end
        do_reset();
        load(4'b0010);
        bus.int_save = 1'b1;
        step();
        bus.rti_restore = 1'b1;
        bus.setc        = 1'b1;
        step();
        idle();
        tests++;
        if (bus.save_depth !== 2'd1 || bus.stack_err !== 1'b1
            || bus.flag_mask !== 4'b0110) begin
            fails++;
            $display("FAIL conflict: got %0d/%b/%b want 1/1/0110",
                     bus.save_depth, bus.stack_err, bus.flag_mask);
        end
    endtask

    task automatic test_stall();
        do_reset();
        load(4'b0010);
        bus.int_save = 1'b1;
        step();
        load(4'b1001);
        bus.stall       = 1'b1;
        bus.flag_we     = 4'b1111;
        bus.alu_flags   = 4'b0000;
        bus.rti_restore = 1'b1;
        #1;
        tests++;
        if (bus.flag_fwd !== 4'b1001) begin
            fails++;
            $display("FAIL stall_fwd: got %b want 1001", bus.flag_fwd);
        end
        step();
        tests++;
        if (bus.flag_mask !== 4'b1001 || bus.save_depth !== 2'd1
            || bus.stack_err !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold: got %b/%0d/%b want 1001/1/0",
                     bus.flag_mask, bus.save_depth, bus.stack_err);
        end
        idle();
        bus.rti_restore = 1'b1;
        step();
        idle();
        tests++;
        if (bus.flag_mask !== 4'b0010 || bus.save_depth !== 2'd0) begin
            fails++;
            $display("FAIL unstall_pop: got %b/%0d want 0010/0",
                     bus.flag_mask, bus.save_depth);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle();
        #12;
        rst_n = 1'b1;
        step();
        tests++;
        if (bus.flag_mask !== 4'b0000 || bus.save_depth !== 2'd0
            || bus.stack_err !== 1'b0) begin
            fails++;
            $display("FAIL init_state: got %b/%0d/%b want 0000/0/0",
                     bus.flag_mask, bus.save_depth, bus.stack_err);
        end
        test_reset();
        test_branch_clear();
        test_precedence();
        test_nesting();
        test_errors();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ccr_unit.md
CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port alu_flags  input  4  ALU result flags, bit0=Z, bit1=N, bit2=C, bit3=V.
REQ-004 SHALL have port flag_we  input  4  per-flag write enable for alu_flags, same bit order.
REQ-005 SHALL have port setc  input  1  force C=1 (SETC).
REQ-006 SHALL have port clrc  input  1  force C=0 (CLRC).
REQ-007 SHALL have port br_type  input  3  branch type, encodings BR_NONE=0, JZ=1, JN=2, JC=3, JV=4, LOOP=5, JMP=6, RET=7.
REQ-008 SHALL have port br_taken  input  1  branch resolved taken this cycle.
REQ-009 SHALL have port int_save  input  1  push current flags to shadow stack (interrupt entry).
REQ-010 SHALL have port rti_restore  input  1  pop shadow stack into flags (RTI).
REQ-011 SHALL have port stall  input  1  freeze all state this cycle.
REQ-012 SHALL have port flag_mask  output  4  registered flags, bit order as alu_flags, feeds branch resolution.
REQ-013 SHALL have port flag_fwd  output  4  combinational next-state flags (bypass).
REQ-014 SHALL have port save_depth  output  2  shadow-stack occupancy, 0..2.
REQ-015 SHALL have port stack_err  output  1  sticky overflow/underflow/conflict error.

Function
REQ-016 SHALL update flag_mask one cycle after qualifying inputs; flag_fwd SHALL equal the value flag_mask takes at the next edge.
REQ-017 SHALL, when stall=1, hold flag_mask, stack, save_depth and stack_err; flag_fwd SHALL equal flag_mask.
REQ-018 SHALL apply per-bit precedence, lowest to highest: hold, branch-clear, ALU write, setc/clrc, restore.
REQ-019 SHALL clear the tested flag when br_taken=1 and br_type is JZ(Z), JN(N), JC(C) or JV(V); LOOP, JMP, RET, NONE SHALL clear nothing.
REQ-020 SHALL load alu_flags[i] into flag i where flag_we[i]=1, overriding branch-clear on that bit.
REQ-021 SHALL force C per setc/clrc over ALU write; setc=clrc=1 SHALL give C=0.
REQ-022 SHALL on int_save (depth<2) push the pre-update flag_mask, depth+1; same-cycle ALU/branch/setc updates still apply to flag_mask.
REQ-023 SHALL on rti_restore (depth>0) load the top entry into all four flags, depth-1, ignoring all other same-cycle flag updates.
REQ-024 SHALL treat int_save at depth 2 as overflow: no push, set stack_err, other updates proceed.
REQ-025 SHALL treat rti_restore at depth 0 as underflow: no pop, set stack_err, other updates proceed.
REQ-026 SHALL treat int_save and rti_restore both 1 as conflict: no stack change, set stack_err, other updates proceed.
REQ-027 SHALL clear stack_err only by reset.
REQ-028 SHALL be a LIFO: entry pushed last is restored first.

Reset
REQ-029 SHALL on rst_n=0, immediately and regardless of clk, set flag_mask=4'b0000, save_depth=0, stack_err=0, stack entries=0.
REQ-030 SHALL, if reset asserts mid-sequence (e.g. between save and restore), discard stack contents; first edge after release behaves from reset state.

Structure
REQ-031 SHALL take br_type encodings, flag bit indices (Z=0,N=1,C=2,V=3) and stack depth (2) from a shared package also used by the branch unit.
REQ-032 SHALL place the 2-entry shadow stack, depth counter and error detection in sub-module ccr_shadow_stack.

Verification
REQ-033 Reset: rst_n=0 with flag_mask=4'b1111 -> flag_mask=0, save_depth=0, stack_err=0 before next clk edge.
REQ-034 Branch clear: flag_mask=4'b0101, br_type=JZ, br_taken=1 -> next flag_mask=4'b0100; same with br_type=LOOP -> 4'b0101 unchanged.
REQ-035 Precedence: flag_mask=0, alu_flags=4'b1111, flag_we=4'b0100, clrc=1 -> flag_fwd and next flag_mask=4'b0000; setc=1 instead -> 4'b0100.
REQ-036 Nesting: flags 4'b0011 save, flags 4'b1000 save, write 0, restore, restore -> flag_mask 4'b1000 then 4'b0011, save_depth 1,2,2,1,0, stack_err=0.
REQ-037 Errors: third int_save at depth 2 -> depth stays 2, stack_err=1; restore at depth 0 -> flags unchanged, stack_err=1 until reset.
REQ-038 Stall: stall=1 with flag_we=4'b1111, rti_restore=1 at depth 1 -> flag_mask, save_depth unchanged, flag_fwd=flag_mask.
